// File: rtl/gate_truth_table_sequencer_if.sv
// Bundle between the test/config master, the sequencer and the gate under test.
// The master view also drives c, since the gate model lives on the environment side.
`timescale 1ns/1ps
interface gate_truth_table_sequencer_if;
  logic       start;
  logic [3:0] expected;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] result;
  logic [3:0] fail_mask;

  modport master (
    output start, expected, c,
    input  a, b, busy, done, pass, result, fail_mask
  );

  modport slave (
    input  start, expected, c,
    output a, b, busy, done, pass, result, fail_mask
  );
endinterface

// File: rtl/gate_truth_table_sequencer.sv
// Walks a 2-input gate through all four input vectors, holding each for HOLD cycles,
// captures the gate output at the last held edge and compares against the expected table.
`timescale 1ns/1ps
module gate_truth_table_sequencer #(
  parameter int unsigned HOLD = 4
) (
  input logic                          clk,
  input logic                          rst,
  gate_truth_table_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     r_state;
  logic [1:0] r_idx;
  logic [7:0] r_cnt;
  logic [3:0] r_exp;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_result;
  logic [3:0] r_fail_mask;

  logic [3:0] w_fail_next;
  logic [3:0] w_result_next;
  logic [1:0] w_idx_next;

  // Mask including the current capture, so pass can see vector 3 at the DONE transition.
  always_comb begin
    w_fail_next           = r_fail_mask;
    w_fail_next[r_idx]    = bus.c ^ r_exp[r_idx];
    w_result_next         = r_result;
    w_result_next[r_idx]  = bus.c;
    w_idx_next            = r_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_exp       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_result    <= '0;
      r_fail_mask <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_a    <= 1'b0;
          r_b    <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (bus.start) begin
            r_exp       <= bus.expected;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_fail_mask <= '0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_cnt == HOLD_LAST) begin
            r_result    <= w_result_next;
            r_fail_mask <= w_fail_next;
            r_cnt       <= '0;
            if (r_idx == 2'd3) begin
              r_a     <= 1'b0;
              r_b     <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_fail_next == '0);
              r_state <= DONE;
            end else begin
              r_idx <= w_idx_next;
              r_a   <= w_idx_next[0];
              r_b   <= w_idx_next[1];
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.result    = r_result;
  assign bus.fail_mask = r_fail_mask;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed bench: HOLD=4 sequencer driving an AND gate (with an injectable output flip)
// and a HOLD=1 sequencer driving a plain AND gate.
`timescale 1ns/1ps
module tb_gate_truth_table_sequencer;

  logic        clk;
  logic        rst;
  logic        flip;
  int unsigned n_checks;
  int unsigned n_errors;

  gate_truth_table_sequencer_if bus4 ();
  gate_truth_table_sequencer_if bus1 ();

  assign bus4.c = (bus4.a & bus4.b) ^ flip;
  assign bus1.c = bus1.a & bus1.b;

  gate_truth_table_sequencer #(.HOLD(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  gate_truth_table_sequencer #(.HOLD(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One HOLD=4 run; fl[k] flips c during the cycle after edge E0+k.
  // disturb: expected->0 sampled from E0+3, extra start pulse sampled at E0+5.
  task automatic run4(input logic [3:0] e, input logic [15:0] fl, input bit disturb,
                      input logic [3:0] er, input logic [3:0] em, input logic ep);
    logic [1:0] vi;
    bus4.expected = e;
    bus4.start    = 1'b1;
    step();
    bus4.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      vi = 2'(k / 4);
      chk1("run_a", bus4.a, vi[0]);
      chk1("run_b", bus4.b, vi[1]);
      chk1("run_busy", bus4.busy, 1'b1);
      chk1("run_done_early", bus4.done, 1'b0);
      flip = fl[k];
      if (disturb) begin
        if (k == 2) bus4.expected = 4'b0000;
        if (k == 4) bus4.start = 1'b1;
        if (k == 5) bus4.start = 1'b0;
      end
      step();
    end
    flip = 1'b0;
    chk1("end_done", bus4.done, 1'b1);
    chk1("end_busy", bus4.busy, 1'b0);
    chk1("end_a", bus4.a, 1'b0);
    chk1("end_b", bus4.b, 1'b0);
    chk1("end_pass", bus4.pass, ep);
    chk4("end_result", bus4.result, er);
    chk4("end_mask", bus4.fail_mask, em);
    step();
    chk1("idle_done", bus4.done, 1'b0);
    chk1("idle_busy", bus4.busy, 1'b0);
    chk4("idle_result_hold", bus4.result, er);
    chk1("idle_pass_hold", bus4.pass, ep);
  endtask

  initial begin
    logic seen_done;
    n_checks      = 0;
    n_errors      = 0;
    flip          = 1'b0;
    rst           = 1'b1;
    bus4.start    = 1'b0;
    bus4.expected = 4'b0000;
    bus1.start    = 1'b0;
    bus1.expected = 4'b0000;
    step();
    step();
    rst = 1'b0;
    chk1("rst_busy", bus4.busy, 1'b0);
    chk1("rst_done", bus4.done, 1'b0);
    chk1("rst_pass", bus4.pass, 1'b0);
    chk1("rst_a", bus4.a, 1'b0);
    chk1("rst_b", bus4.b, 1'b0);
    chk4("rst_result", bus4.result, 4'b0000);
    chk4("rst_mask", bus4.fail_mask, 4'b0000);

    // AND table expected; then OR table expected against the AND gate
    run4(4'b1000, 16'h0000, 1'b0, 4'b1000, 4'b0000, 1'b1);
    run4(4'b1110, 16'h0000, 1'b0, 4'b1000, 4'b0110, 1'b0);
    step();
    step();
    chk4("idle_hold_mask", bus4.fail_mask, 4'b0110);

    // c glitches between captures are ignored; a flip held across vector 2's capture is not
    run4(4'b1000, 16'h0F07, 1'b0, 4'b1100, 4'b0100, 1'b0);

    // Late expected change and extra start during the run have no effect
    run4(4'b1000, 16'h0000, 1'b1, 4'b1000, 4'b0000, 1'b1);
    chk1("disturb_no_restart", bus4.busy, 1'b0);

    // Reset during vector 2, with a flipped capture on vector 0 to make result non-zero
    bus4.expected = 4'b1000;
    bus4.start    = 1'b1;
    step();
    bus4.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      flip = (k == 3);
      step();
    end
    flip = 1'b0;
    chk4("pre_rst_result", bus4.result, 4'b0001);
    chk1("pre_rst_b", bus4.b, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("midrst_busy", bus4.busy, 1'b0);
    chk1("midrst_done", bus4.done, 1'b0);
    chk1("midrst_a", bus4.a, 1'b0);
    chk1("midrst_b", bus4.b, 1'b0);
    chk1("midrst_pass", bus4.pass, 1'b0);
    chk4("midrst_result", bus4.result, 4'b0000);
    chk4("midrst_mask", bus4.fail_mask, 4'b0000);
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus4.done === 1'b1 || bus4.busy === 1'b1) seen_done = 1'b1;
    end
    chk1("midrst_stays_idle", seen_done, 1'b0);
    run4(4'b1000, 16'h0000, 1'b0, 4'b1000, 4'b0000, 1'b1);

    // start held high: period 4*HOLD+2 with one DONE and one IDLE cycle between runs
    bus4.expected = 4'b1000;
    bus4.start    = 1'b1;
    step();
    for (int k = 0; k < 36; k++) begin
      chk1("b2b_busy", bus4.busy, ((k % 18) < 16));
      chk1("b2b_done", bus4.done, ((k % 18) == 16));
      if (k == 35) bus4.start = 1'b0;
      step();
    end
    chk1("b2b_stop_busy", bus4.busy, 1'b0);
    chk1("b2b_pass", bus4.pass, 1'b1);

    // HOLD=1 instance: one capture per DRIVE cycle
    bus1.expected = 4'b1000;
    bus1.start    = 1'b1;
    step();
    bus1.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("h1_a", bus1.a, 1'((k >> 0) & 1));
      chk1("h1_b", bus1.b, 1'((k >> 1) & 1));
      chk1("h1_busy", bus1.busy, 1'b1);
      step();
    end
    chk1("h1_done", bus1.done, 1'b1);
    chk1("h1_pass", bus1.pass, 1'b1);
    chk4("h1_result", bus1.result, 4'b1000);
    chk4("h1_mask", bus1.fail_mask, 4'b0000);
    step();
    chk1("h1_done_clear", bus1.done, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_sequencer.md
Name: gate_truth_table_sequencer

Overview:
- Controller that exercises one 2-input gate instance, such as the team's user-defined AND primitive or any 2-in/1-out gate model.
- Steps the gate's inputs through all four input combinations, holding each vector for a programmable settle time, then samples the gate output.
- Compares the sampled outputs against an expected 4-entry truth table and reports pass/fail plus the captured table.
- Sits between a test/config master (start/expected) and the gate datapath (a, b out; c in).

Parameters:
- HOLD, 4, cycles each input vector is driven before the gate output is sampled; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a run; accepted only in IDLE.
- expected  input  4  expected gate output, indexed by vector index (see below); registered at accept.
- a  output  1  gate input a (registered).
- b  output  1  gate input b (registered).
- c  input  1  gate output under test.
- busy  output  1  high while a run is in progress (DRIVE state).
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 if every captured output matched expected; valid from done until next accept.
- result  output  4  captured gate outputs, result[i] for vector i.
- fail_mask  output  4  result XOR registered expected; 1 marks a mismatching vector.

Behaviour:
- Vector index idx (2 bits) maps to inputs as: a = idx[0], b = idx[1].
  - Sequence order: idx0 a=0 b=0, idx1 a=1 b=0, idx2 a=0 b=1, idx3 a=1 b=1.
- Reset (rst=1 at an edge), from any state including mid-run:
  - state goes to IDLE; a=b=0; busy=0; done=0; pass=0; result=0; fail_mask=0.
  - idx=0, hold counter=0, expected register=0.
- IDLE: a=b=0, busy=0.
  - If start=1 at an edge: register expected, set idx=0, counter=0, clear result/fail_mask/pass, go to DRIVE.
- DRIVE: busy=1; a/b reflect idx from the same edge that entered DRIVE or advanced idx.
  - Each edge: counter increments.
  - At the edge where counter==HOLD-1:
    - capture c into result[idx];
    - set fail_mask[idx] = c XOR exp_reg[idx];
    - reset counter to 0;
    - if idx==3, go to DONE; otherwise idx+1.
  - The capture edge is the last edge the vector is held; the next vector is driven immediately after it.
- DONE: single cycle.
  - done=1, busy=0, a=b=0.
  - pass = (fail_mask==0), using the final fail_mask including vector 3.
  - Next edge unconditionally returns to IDLE; start in DONE is ignored.
- Latency, with start accepted at edge E0:
  - vector i is captured at edge E0 + (i+1)*HOLD;
  - DONE is entered at E0 + 4*HOLD, so done is high during the following cycle;
  - the earliest next accept is at E0 + 4*HOLD + 2.
- result, fail_mask and pass hold their values in IDLE until the next accepted start or reset.
- start while busy or in DONE is ignored; no queuing.
- Changes on expected after accept have no effect on the run in progress.
- c is sampled only at capture edges; c activity between captures is ignored.
- An X/Z value on c at a capture counts as a mismatch (bench-visible as fail_mask bit not 0).
- HOLD=1: one cycle per vector; a capture happens every DRIVE cycle.
- Counter width is 8 bits; HOLD=0 is illegal and not supported.

Test Plan:
- HOLD=4, c driven by my_and(c,a,b), expected=4'b1000, one-cycle start → a/b sequence 00,10,01,11, each held 4 cycles; done at cycle E0+17; result=1000, fail_mask=0000, pass=1.
- Same setup, expected=4'b1110 (OR table) → result=1000, fail_mask=0110, pass=0.
- start held high continuously → back-to-back runs; exactly one DONE cycle and one IDLE cycle between busy periods; period = 4*HOLD+2 cycles.
- Pulse start again at E0+5, and change expected to 4'b0000 at E0+3 → run unaffected; second start ignored; final pass=1 with expected=1000.
- Assert rst for one cycle at E0+9 (during idx2) → next cycle IDLE, a=b=0, busy=0, result=0, pass=0, no done pulse; a subsequent start gives a full clean run.
- HOLD=1 build, expected=1000 → captures on 4 consecutive edges; done during cycle E0+5; pass=1.
